// File: rtl/pipe_lane_if.sv
// pipe_lane_if: bundle handshake between issue-wide pipeline stages.
// The slave modport is the register; the master modport drives it from both sides.
interface pipe_lane_if #(
    parameter int LANES = 2,
    parameter int DW    = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [LANES-1:0]    in_lane_v;
    logic [LANES-1:0]    in_kill;
    logic [LANES*DW-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [LANES-1:0]    out_lane_v;
    logic [LANES*DW-1:0] out_data;
    logic [1:0]          count;
    modport slave (
        input  in_valid, in_lane_v, in_kill, in_data, out_ready,
        output in_ready, out_valid, out_lane_v, out_data, count
    );
    modport master (
        output in_valid, in_lane_v, in_kill, in_data, out_ready,
        input  in_ready, out_valid, out_lane_v, out_data, count
    );
endinterface

// File: rtl/pipe_lane_reg.sv
// pipe_lane_reg: multi-lane valid/ready pipeline register with per-lane kill and stage flush.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_lane_reg #(
    parameter int LANES = 2,
    parameter int DW    = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    pipe_lane_if.slave bus
);
    localparam int W = LANES * DW;
    logic [LANES-1:0] ev, h_v, h_v_n;
    logic [W-1:0]     cap, h_d, h_d_n;
    logic [1:0]       cnt, cnt_n;
    logic             push, pop, store;
    assign ev = bus.in_lane_v & ~bus.in_kill;
    for (genvar l = 0; l < LANES; l++) begin : g_cap
        assign cap[l*DW +: DW] = ev[l] ? bus.in_data[l*DW +: DW] : '0;
    end
    assign push           = bus.in_valid & bus.in_ready;
    assign pop            = bus.out_valid & bus.out_ready;
    // A fully squashed bundle still completes its handshake but occupies nothing
    assign store          = push & |ev & ~flush;
    assign bus.out_valid  = cnt != 2'd0;
    assign bus.out_lane_v = h_v;
    assign bus.out_data   = h_d;
    assign bus.count      = cnt;
`ifdef PIPE_SKID_EN
    logic [LANES-1:0] s_v, s_v_n;
    logic [W-1:0]     s_d, s_d_n;
    assign bus.in_ready = cnt != 2'd2;
    always_comb begin
        cnt_n = cnt;
        h_v_n = h_v;
        h_d_n = h_d;
        s_v_n = s_v;
        s_d_n = s_d;
        if (flush) begin
            cnt_n = 2'd0;
            h_v_n = '0;
            s_v_n = '0;
        end else if (store && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
            cnt_n = 2'd1;
            h_v_n = ev;
            h_d_n = cap;
        end else if (store && pop) begin
            h_v_n = s_v;
            h_d_n = s_d;
            s_v_n = ev;
            s_d_n = cap;
        end else if (store) begin
            cnt_n = 2'd2;
            s_v_n = ev;
            s_d_n = cap;
        end else if (pop && cnt == 2'd2) begin
            cnt_n = 2'd1;
            h_v_n = s_v;
            h_d_n = s_d;
            s_v_n = '0;
        end else if (pop) begin
            cnt_n = 2'd0;
            h_v_n = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s_v <= '0;
            s_d <= '0;
        end else begin
            s_v <= s_v_n;
            s_d <= s_d_n;
        end
`else
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    always_comb begin
        cnt_n = cnt;
        h_v_n = h_v;
        h_d_n = h_d;
        if (flush || (pop && !store)) begin
            cnt_n = 2'd0;
            h_v_n = '0;
        end else if (store) begin
            cnt_n = 2'd1;
            h_v_n = ev;
            h_d_n = cap;
        end
    end
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= 2'd0;
            h_v <= '0;
            h_d <= '0;
        end else begin
            cnt <= cnt_n;
            h_v <= h_v_n;
            h_d <= h_d_n;
        end
endmodule

// File: tb/tb_pipe_lane_reg.sv
// tb_pipe_lane_reg: scoreboard bench for pipe_lane_reg; the reference is a bounded queue of
// bundles (capacity 1, or 2 with PIPE_SKID_EN) fed at stimulus time and drained by a monitor.
module tb_pipe_lane_reg;
    localparam int LANES = 2;
    localparam int DW    = 8;
    localparam int W     = LANES * DW;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    logic exp_rdy = 1'b1;
    logic [LANES-1:0] m_ev;
    logic [W-1:0] m_d;
    logic [LANES+W-1:0] q[$];
    pipe_lane_if #(.LANES(LANES), .DW(DW)) bus();
    pipe_lane_reg #(.LANES(LANES), .DW(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask
    task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [LANES-1:0] kl,
                         input logic [W-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #2;
        bus.in_valid  = v;
        bus.in_lane_v = lv;
        bus.in_kill   = kl;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
    endtask
    task automatic idle(input int n, input logic ordy);
        repeat (n) drive(1'b0, '0, '0, '0, ordy, 1'b0);
    endtask
    // Monitor: compare the head against the scoreboard, retire it when consumed
    always @(negedge clk) begin
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || bus.out_ready);
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_lane_v", 32'(bus.out_lane_v), 32'(q[0][W +: LANES]));
            chk("out_data", 32'(bus.out_data), 32'(q[0][W-1:0]));
            if (bus.out_ready) void'(q.pop_front());
        end else begin
            chk("out_lane_v_empty", 32'(bus.out_lane_v), 32'd0);
        end
    end
    // Stimulus side of the scoreboard: record each accepted, non-empty bundle
    always begin
        @(negedge clk);
        #2;
        if (!rst_n || flush) begin
            q.delete();
        end else if (bus.in_valid && exp_rdy) begin
            m_ev = bus.in_lane_v & ~bus.in_kill;
            m_d  = bus.in_data;
            for (int i = 0; i < LANES; i++)
                if (!m_ev[i]) m_d[i*DW +: DW] = '0;
            if (m_ev != '0) q.push_back({m_ev, m_d});
        end
    end
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_lane_v = '0;
        bus.in_kill   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_lane_v", 32'(bus.out_lane_v), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // back-to-back stream
        drive(1'b1, 2'b11, 2'b00, 16'h2211, 1'b1, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 16'h4433, 1'b1, 1'b0);
        idle(3, 1'b1);
        // per-lane kill, then a fully killed bundle
        drive(1'b1, 2'b11, 2'b10, 16'hAA55, 1'b1, 1'b0);
        drive(1'b1, 2'b11, 2'b11, 16'h7777, 1'b1, 1'b0);
        idle(3, 1'b1);
        // backpressure with three offered bundles
        drive(1'b1, 2'b11, 2'b00, 16'hA0A1, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 2'b00, 16'hB0B1, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 2'b00, 16'hC0C1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        // hold one bundle, then pop it while a new one is offered
        drive(1'b1, 2'b11, 2'b00, 16'h0A0A, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 16'h0B0B, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        // flush with a full register and a bundle arriving
        drive(1'b1, 2'b11, 2'b00, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 16'h5678, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 16'h9ABC, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);
        // asynchronous reset while holding a bundle
        drive(1'b1, 2'b11, 2'b00, 16'h5A5A, 1'b0, 1'b0);
        idle(1, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_lane_v", 32'(bus.out_lane_v), 32'd0);
        chk("arst_out_data", 32'(bus.out_data), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("arst_release_in_ready", 32'(bus.in_ready), 32'd1);
        // randomized traffic
        for (int k = 0; k < 400; k++)
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        idle(4, 1'b1);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_lane_reg.md
# pipe_lane_reg

Parametrised multi-lane pipeline register with a valid/ready handshake, placed between issue-wide stages (decode→execute, execute→writeback) of the dual-issue core. It moves a bundle of LANES instruction slots as one unit, carries per-lane valid bits, drops squashed lanes at capture and supports whole-stage flush on branch redirect. An optional 2-entry skid buffer registers the ready path.

## Interface
Parameters:
- LANES, 2, number of issue slots per bundle (1..4)
- DW, 128, payload width per lane (pc, npc, decode word, operands, order tag packed by the user)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- flush  in  1  synchronous kill of all held and incoming bundles (branch redirect)
- in_valid  in  1  upstream bundle present
- in_ready  out  1  block accepts a bundle this cycle
- in_lane_v  in  LANES  per-lane valid of incoming bundle
- in_kill  in  LANES  per-lane squash applied at capture (e.g. younger lane behind a taken branch)
- in_data  in  LANES*DW  lane i at bits [i*DW +: DW]
- out_valid  out  1  head bundle present
- out_ready  in  1  downstream consumes head this cycle
- out_lane_v  out  LANES  per-lane valid of head bundle
- out_data  out  LANES*DW  head payload
- count  out  2  bundles held (0..1 base, 0..2 with skid)

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Effective lane valid at capture: ev = in_lane_v & ~in_kill. Lanes with ev=0 stored with payload forced to 0.
- Push with ev == 0 (all lanes invalid/killed): handshake completes, nothing stored, count unchanged.
- Base mode: one entry. in_ready = ~out_valid | out_ready (combinational from out_ready). Push and pop in same cycle: new bundle replaces head, count stays 1.
- Skid mode: head + skid entry, FIFO order. in_ready = (count != 2), from registered state only. Push while head occupied and no pop → bundle into skid, count=2. Pop with skid occupied → skid moves to head.
- flush: at next edge count=0, out_valid=0, out_lane_v=0; any push in the same cycle discarded. A pop in the flush cycle counts as completed downstream. flush has priority over push.
- out_valid = (count != 0); out_lane_v/out_data reflect head entry; with count=0 out_data holds last value, out_lane_v=0.
- Lane order preserved: lane 0 of in maps to lane 0 of out; no compaction.

## Timing
- Reset (rst_n low, asynchronous, immediate): out_valid=0, out_lane_v=0, out_data=0, count=0, skid entry cleared; in_ready=1 once reset state applies (both modes). Reset mid-transfer discards all held bundles.
- Latency: push at edge N → out_valid at N+1 (both modes; skid adds no latency when empty).
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- Base mode: out_ready low with head full → in_ready low same cycle.
- Skid mode: in_ready falls the cycle after count reaches 2; rises the cycle after a pop from count=2.
- out_data/out_lane_v stable while out_valid=1 and out_ready=0.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid buffer, in_ready registered, count range 0..2.
- PIPE_SKID_EN undefined: single entry, in_ready combinational from out_ready, count range 0..1, count[1] tied 0.

## Test plan
- Stream: LANES=2, DW=8, out_ready=1, push bundles lane data {0x11,0x22},{0x33,0x44} back-to-back, lane_v=2'b11 → out at N+1, N+2 in order, out_valid high two cycles.
- Kill: push lane_v=2'b11, in_kill=2'b10, data {0xAA,0x55} → out_lane_v=2'b01, out_data lane1=0x00, lane0=0x55; push with in_kill=2'b11 → out_valid stays 0, count 0.
- Backpressure (skid on): out_ready=0, push A,B,C → A,B held, count=2, in_ready=0 from next cycle, C not accepted; out_ready=1 → A then B, in_ready=1 after first pop.
- Backpressure (skid off): out_ready=0 after push A → in_ready=0 same cycle; A held stable; pulse out_ready with in_valid=1 carrying B → A popped, B captured, count=1.
- Flush: count=2, flush=1 with in_valid=1 → next cycle count=0, out_valid=0, incoming bundle absent.
- Async reset: assert rst_n=0 mid-cycle with count=1 → out_valid/out_lane_v/out_data/count = 0 before next clk edge; release → in_ready=1.
